// File: rtl/fetch_if_id.sv
// Instruction fetch stage with single-outstanding imem handshake and IF/ID register.
// Optional build macro FETCH_PERF_CNT_EN adds saturating bubble/stall counters.
module fetch_if_id #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic [15:0] inst_sel,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] inst_If,
    output logic [15:0] pc_If,
    output logic [15:0] inst_IfId,
    output logic [15:0] pcp2_IfId,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_bubble,
    output logic [15:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] hold_buf, hold_buf_nxt;
    logic        squash, squash_nxt;
    logic        halted_nxt;
    logic [15:0] inst_ifid_nxt;
    logic [15:0] pcp2_ifid_nxt;
    logic [15:0] pc_p2;
    logic        avail;
    logic        is_halt;
    logic        bubble_ev;
    logic        stall_ev;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign pc_p2     = pc + 16'd2;
    assign avail     = ((state == S_WAIT) && imem_valid && !squash) || (state == S_HOLD);
    assign inst_If   = (state == S_HOLD) ? hold_buf : (avail ? imem_data : NOP_INST);
    assign pc_If     = pc;
    assign imem_addr = pc;
    assign is_halt   = (inst_If[15:11] == 5'b00000) && (inst_sel == inst_If);
    // A redirect in the request cycle cancels the request so at most one is ever in flight.
    assign imem_req  = rst && (state == S_FETCH) && !redirect;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        hold_buf_nxt  = hold_buf;
        squash_nxt    = squash;
        halted_nxt    = halted;
        inst_ifid_nxt = NOP_INST;
        pcp2_ifid_nxt = pcp2_IfId;
        bubble_ev     = 1'b0;
        stall_ev      = 1'b0;
        if (redirect) begin
            pc_nxt     = redirect_pc & 16'hFFFE;
            halted_nxt = 1'b0;
            if ((state == S_WAIT) && !imem_valid) begin
                squash_nxt = 1'b1;
                state_nxt  = S_WAIT;
            end else begin
                squash_nxt = 1'b0;
                state_nxt  = S_FETCH;
            end
        end else if (avail) begin
            inst_ifid_nxt = inst_sel;
            if (stall) begin
                hold_buf_nxt = inst_If;
                state_nxt    = S_HOLD;
                stall_ev     = 1'b1;
            end else begin
                pcp2_ifid_nxt = pc_p2;
                if (is_halt) begin
                    state_nxt  = S_HALT;
                    halted_nxt = 1'b1;
                end else begin
                    pc_nxt    = pc_p2;
                    state_nxt = S_FETCH;
                end
            end
        end else begin
            bubble_ev = (state != S_HALT);
            case (state)
                S_FETCH: state_nxt = S_WAIT;
                S_WAIT: begin
                    // Only a squashed response can land here; drop it and refetch.
                    if (imem_valid) begin
                        state_nxt  = S_FETCH;
                        squash_nxt = 1'b0;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            squash    <= 1'b0;
            halted    <= 1'b0;
            inst_IfId <= NOP_INST;
            pcp2_IfId <= 16'h0000;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            squash    <= squash_nxt;
            halted    <= halted_nxt;
            inst_IfId <= inst_ifid_nxt;
            pcp2_IfId <= pcp2_ifid_nxt;
        end
    end

    // The buffer is only read in HOLD, so its contents need no reset.
    always_ff @(posedge clk) begin
        hold_buf <= hold_buf_nxt;
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_bubble <= 16'h0000;
            perf_stall  <= 16'h0000;
        end else begin
            if (bubble_ev) perf_bubble <= sat_inc(perf_bubble);
            if (stall_ev)  perf_stall  <= sat_inc(perf_stall);
        end
    end
`else
    logic unused_ev;
    assign unused_ev = bubble_ev ^ stall_ev ^ (sat_inc(16'h0000) == 16'h0000);
`endif

endmodule

// File: tb/tb_fetch_if_id.sv
// Directed bench for fetch_if_id: imem model with programmable latency, stall/redirect/halt/reset steps.
// Perf counter checks are compiled only when FETCH_PERF_CNT_EN is defined.
module tb_fetch_if_id;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        stall;
    logic [15:0] inst_sel;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] inst_If;
    logic [15:0] pc_If;
    logic [15:0] inst_IfId;
    logic [15:0] pcp2_IfId;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_bubble;
    logic [15:0] perf_stall;
`endif

    logic [15:0] mem [0:32767];
    int          lat = 1;
    int          cnt = 0;
    logic [15:0] maddr = 16'h0000;
    logic        m_seen = 1'b0;
    logic [15:0] m_a = 16'h0000;
    logic        mdl_valid = 1'b0;
    logic [15:0] mdl_data = 16'h0000;
    logic        inj_valid = 1'b0;
    logic [15:0] inj_data = 16'h0000;
    logic        sel_ovr = 1'b0;
    logic [15:0] sel_val = 16'h0000;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign imem_valid = mdl_valid | inj_valid;
    assign imem_data  = inj_valid ? inj_data : mdl_data;
    assign inst_sel   = sel_ovr ? sel_val : inst_If;

    fetch_if_id dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_valid(imem_valid),
        .imem_data(imem_data),
        .stall(stall),
        .inst_sel(inst_sel),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .inst_If(inst_If),
        .pc_If(pc_If),
        .inst_IfId(inst_IfId),
        .pcp2_IfId(pcp2_IfId),
        .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_bubble(perf_bubble),
        .perf_stall(perf_stall)
`endif
    );

    // Request accepted at a rising edge; response valid for one cycle, lat cycles later.
    always begin
        @(posedge clk);
        m_seen = imem_req;
        m_a    = imem_addr;
        @(negedge clk);
        mdl_valid = 1'b0;
        if (!rst) begin
            cnt = 0;
        end else begin
            if (m_seen) begin
                cnt   = lat;
                maddr = m_a;
            end
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    mdl_valid = 1'b1;
                    mdl_data  = mem[maddr[15:1]];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        for (int i = 0; i < 32768; i++) mem[i] = {4'h4, i[11:0]};
        mem[1] = 16'h4801;
        mem[2] = 16'h8C20;
        mem[3] = 16'h0000;

        step(); step();
        chk("rst_pc", pc_If, 16'h0000);
        chk("rst_ifid", inst_IfId, 16'h0800);
        chk("rst_pcp2", pcp2_IfId, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'h0000);
        chk("rst_req", {15'd0, imem_req}, 16'h0000);
        chk("rst_instif", inst_If, 16'h0800);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_b", perf_bubble, 16'h0000);
        chk("rst_perf_s", perf_stall, 16'h0000);
`endif
        rst = 1'b1; #1;
        chk("f0_req", {15'd0, imem_req}, 16'h0001);
        chk("f0_addr", imem_addr, 16'h0000);
        step(); chk("f0_instif", inst_If, 16'h4000);
        step();
        chk("f0_ifid", inst_IfId, 16'h4000);
        chk("f0_pcp2", pcp2_IfId, 16'h0002);
        chk("f1_addr", imem_addr, 16'h0002);
        chk("f1_req", {15'd0, imem_req}, 16'h0001);
        step(); chk("f1_instif", inst_If, 16'h4801);
        step();
        chk("f1_ifid", inst_IfId, 16'h4801);
        chk("f1_pcp2", pcp2_IfId, 16'h0004);
        chk("f2_addr", imem_addr, 16'h0004);

        // stall for three cycles on 8C20
        step(); chk("st_instif", inst_If, 16'h8C20);
        stall = 1'b1; sel_ovr = 1'b1; sel_val = 16'h0800;
        step();
        chk("st1_req", {15'd0, imem_req}, 16'h0000);
        chk("st1_ifid", inst_IfId, 16'h0800);
        chk("st1_pc", pc_If, 16'h0004);
        step();
        chk("st2_req", {15'd0, imem_req}, 16'h0000);
        chk("st2_ifid", inst_IfId, 16'h0800);
        step();
        chk("st3_ifid", inst_IfId, 16'h0800);
        chk("st3_instif", inst_If, 16'h8C20);
        chk("st3_pc", pc_If, 16'h0004);
        stall = 1'b0; sel_ovr = 1'b0;
        step();
        chk("st_rel_ifid", inst_IfId, 16'h8C20);
        chk("st_rel_pcp2", pcp2_IfId, 16'h0006);
        chk("st_rel_addr", imem_addr, 16'h0006);

        // HALT at 0x0006
        step(); chk("h_instif", inst_If, 16'h0000);
        step();
        chk("h_halted", {15'd0, halted}, 16'h0001);
        chk("h_ifid", inst_IfId, 16'h0000);
        chk("h_req", {15'd0, imem_req}, 16'h0000);
        chk("h_pc", pc_If, 16'h0006);
        step(); chk("h_ifid_nop", inst_IfId, 16'h0800);
        step();
        chk("h_req2", {15'd0, imem_req}, 16'h0000);
        chk("h_ifid_nop2", inst_IfId, 16'h0800);
        chk("h_halted2", {15'd0, halted}, 16'h0001);
        redirect = 1'b1; redirect_pc = 16'h0020;
        step(); redirect = 1'b0; #1;
        chk("hr_halted", {15'd0, halted}, 16'h0000);
        chk("hr_addr", imem_addr, 16'h0020);
        chk("hr_req", {15'd0, imem_req}, 16'h0001);
        chk("hr_ifid", inst_IfId, 16'h0800);
        step();
        step();
        chk("hr_ifid2", inst_IfId, 16'h4010);
        chk("hr_pcp2", pcp2_IfId, 16'h0022);

        // redirect while a 4-cycle request to 0x0010 is outstanding
        redirect = 1'b1; redirect_pc = 16'h0010;
        step(); redirect = 1'b0; lat = 4; #1;
        chk("sq_addr10", imem_addr, 16'h0010);
        chk("sq_req10", {15'd0, imem_req}, 16'h0001);
        step();
        redirect = 1'b1; redirect_pc = 16'h0041;
        step(); redirect = 1'b0; #1;
        chk("sq_req_a", {15'd0, imem_req}, 16'h0000);
        chk("sq_ifid_a", inst_IfId, 16'h0800);
        chk("sq_pc", pc_If, 16'h0040);
        step(); chk("sq_req_b", {15'd0, imem_req}, 16'h0000);
        step();
        chk("sq_stale_instif", inst_If, 16'h0800);
        chk("sq_ifid_b", inst_IfId, 16'h0800);
        step(); lat = 1;
        chk("sq_addr40", imem_addr, 16'h0040);
        chk("sq_req40", {15'd0, imem_req}, 16'h0001);
        chk("sq_ifid_c", inst_IfId, 16'h0800);
        step();
        step();
        chk("sq_ifid40", inst_IfId, 16'h4020);
        chk("sq_pcp2", pcp2_IfId, 16'h0042);

        // PC wrap at FFFE
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step(); redirect = 1'b0; #1;
        chk("wr_addr", imem_addr, 16'hFFFE);
        step();
        step();
        chk("wr_ifid", inst_IfId, 16'h4FFF);
        chk("wr_pcp2", pcp2_IfId, 16'h0000);
        chk("wr_addr0", imem_addr, 16'h0000);
        chk("wr_req", {15'd0, imem_req}, 16'h0001);

        // redirect coincident with a response
        step(); chk("cv_instif", inst_If, 16'h4000);
        redirect = 1'b1; redirect_pc = 16'h0030;
        step(); redirect = 1'b0; #1;
        chk("cv_ifid", inst_IfId, 16'h0800);
        chk("cv_addr", imem_addr, 16'h0030);
        chk("cv_req", {15'd0, imem_req}, 16'h0001);
        step();
        step();
        chk("cv_ifid2", inst_IfId, 16'h4018);
        chk("cv_pcp2", pcp2_IfId, 16'h0032);

        // reset during WAIT, then a late response while in FETCH
        lat = 6;
        step();
        rst = 1'b0; #1;
        chk("mr_pc", pc_If, 16'h0000);
        chk("mr_ifid", inst_IfId, 16'h0800);
        chk("mr_req", {15'd0, imem_req}, 16'h0000);
        chk("mr_pcp2", pcp2_IfId, 16'h0000);
        chk("mr_halted", {15'd0, halted}, 16'h0000);
        step();
        lat = 1; rst = 1'b1; inj_valid = 1'b1; inj_data = 16'h1234; #1;
        chk("mr_req2", {15'd0, imem_req}, 16'h0001);
        chk("mr_addr", imem_addr, 16'h0000);
        chk("mr_late_instif", inst_If, 16'h0800);
        step(); inj_valid = 1'b0; #1;
        chk("mr_instif", inst_If, 16'h4000);
        step();
        chk("mr_ifid2", inst_IfId, 16'h4000);
        chk("mr_pcp2b", pcp2_IfId, 16'h0002);

        // five stall cycles after two memory-wait bubbles since reset
        step();
        stall = 1'b1; sel_ovr = 1'b1; sel_val = 16'h0800;
        repeat (4) step();
        step();
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall", perf_stall, 16'h0005);
        chk("perf_bubble", perf_bubble, 16'h0002);
`endif
        chk("ps_ifid", inst_IfId, 16'h0800);
        chk("ps_pc", pc_If, 16'h0002);
        stall = 1'b0; sel_ovr = 1'b0;
        step();
        chk("ps_rel_ifid", inst_IfId, 16'h4801);
        chk("ps_rel_pcp2", pcp2_IfId, 16'h0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_if_id.md
Name: fetch_if_id

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 16-bit five-stage pipeline.
- Owns the PC and a single-outstanding-request instruction-memory handshake.
- Presents the raw fetched word (inst_If) to the hazard/stall logic, and loads IF/ID with the filtered instruction (inst_sel) returned by that logic.
- Handles branch redirect, stall hold and HALT stop.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INST, 16'h0800, bubble encoding (opcode 5'b00001)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
imem_req  out  1  fetch request, valid with imem_addr
imem_addr  out  16  fetch address (= pc)
imem_valid  in  1  response valid, at least 1 cycle after accepted request
imem_data  in  16  response instruction word
stall  in  1  hazard stall from stall logic
inst_sel  in  16  instruction chosen by stall logic (fetched word, NOP or 16'h0000)
redirect  in  1  taken branch/jump from EX
redirect_pc  in  16  target PC; bit 0 forced to 0
inst_If  out  16  current fetched word, or NOP_INST if none available
pc_If  out  16  PC of inst_If
inst_IfId  out  16  IF/ID instruction register
pcp2_IfId  out  16  IF/ID PC+2 register
halted  out  1  fetch stopped on HALT

Behaviour:
- Reset values:
  - pc=RESET_PC, state=FETCH, inst_IfId=NOP_INST, pcp2_IfId=0.
  - halted=0, squash=0, buffer empty, imem_req=0.
- States:
  - FETCH: imem_req=1 for one cycle, then WAIT.
  - WAIT: imem_req=0 until imem_valid.
  - HOLD: word buffered because of stall.
  - HALT: no requests.
- Exactly one request outstanding. No new request is issued before the response returns.
- "avail" = (state==WAIT & imem_valid & ~squash) | state==HOLD. inst_If = buffer in HOLD, imem_data when avail in WAIT, else NOP_INST.
- Advance (avail & ~stall & ~redirect):
  - inst_IfId<=inst_sel, pcp2_IfId<=pc+2, pc<=pc+2 (16-bit wrap, FFFE->0000), state<=FETCH.
  - Latency: request cycle to IF/ID load is at least 2 cycles.
- Stall (avail & stall & ~redirect):
  - inst_IfId<=inst_sel (bubble supplied by stall logic).
  - pc held; word captured into buffer; state<=HOLD.
  - Stays in HOLD, with no re-fetch, until stall=0, then advances from the buffer.
- Not avail & ~redirect: inst_IfId<=NOP_INST, pcp2_IfId unchanged.
- Redirect (highest priority, any state including HALT):
  - pc<=redirect_pc&16'hFFFE, inst_IfId<=NOP_INST, buffer dropped, halted<=0.
  - If a request is outstanding (WAIT without imem_valid this cycle): squash<=1, state stays WAIT; the response is discarded on arrival, then state<=FETCH with squash<=0.
  - Otherwise state<=FETCH.
- Redirect coincident with imem_valid: the response is discarded, squash stays 0, state<=FETCH.
- HALT: on advance where inst_If[15:11]==5'b00000 and inst_sel==inst_If:
  - the word is loaded into IF/ID, pc is not incremented, state<=HALT, halted<=1.
  - In HALT, inst_IfId<=NOP_INST every cycle until redirect or reset.
- rst asserted mid-transaction: all state returns to reset values immediately. An imem_valid arriving after rst deassert while state==FETCH is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_bubble [15:0] and perf_stall [15:0], both saturating at 16'hFFFF and cleared by rst.
  - perf_bubble increments each cycle IF/ID loads NOP_INST because no word is available.
  - perf_stall increments each cycle with avail & stall.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, memory with 1-cycle latency, program 16'h4000,16'h4801 at 0x0000 -> imem_addr 0000,0002,0004 on successive requests; IF/ID shows 4000 then 4801; pcp2_IfId 0002 then 0004.
- Stall held 3 cycles while inst_If=16'h8C20 -> no imem_req; IF/ID loads inst_sel=0800 for 3 cycles; pc unchanged; 8C20 loaded on the first cycle stall=0.
- Redirect to 16'h0041 while a request to 0x0010 is outstanding, with 4-cycle latency -> stale response discarded; next imem_addr=0x0040; IF/ID=0800 meanwhile.
- HALT 16'h0000 fetched at 0x0006 -> halted=1; no further imem_req; IF/ID=0800 thereafter; redirect to 0x0020 -> halted=0 and fetch resumes at 0x0020.
- PC at 16'hFFFE advances -> next imem_addr=0000. Assert rst during WAIT -> pc=RESET_PC, inst_IfId=0800, late imem_valid ignored.
- With FETCH_PERF_CNT_EN defined, 5 stall cycles and 2 memory-wait bubbles -> perf_stall=5, perf_bubble=2.
